// File: rtl/jpeg_pkg.sv
// ============================================================================
// Module : jpeg_pkg
// Brief  : JPEG zigzag scan table, ZRL run constant and run-length symbol type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package jpeg_pkg;

   // Symbol value field is sized for the widest supported coefficient (<= 16 bits).
   localparam int c_sym_value_w = 16;

   localparam logic [3:0] c_zrl_run = 4'd15;

   // Entry k is the raster index of the k-th coefficient in zigzag order.
   localparam logic [5:0] c_zigzag_lut [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef struct packed {
      logic [3:0]                      run;
      logic signed [c_sym_value_w-1:0] value;
      logic                            eob;
   } rle_sym_t;

endpackage

`default_nettype wire

// File: rtl/zigzag_pingpong_ram.sv
// ============================================================================
// Module : zigzag_pingpong_ram
// Brief  : Two 64-entry coefficient banks, one write port, one registered read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module zigzag_pingpong_ram #(
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [5:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  rd_bank,
   input  logic [5:0]            rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [128];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Read data holds while rd_en is low so a stalled coefficient stays visible.
   always_ff @(posedge clk) begin
      if (wr_en) r_mem[{wr_bank, wr_addr}] <= wr_data;
      if (rd_en) r_rd_data <= r_mem[{rd_bank, rd_addr}];
   end

   assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/zigzag_rle.sv
// ============================================================================
// Module : zigzag_rle
// Brief  : Ping-pong block buffer with zigzag readout; run-length coding when
//          ZIGZAG_RLE_ENCODE_EN is defined, plain zigzag pass-through otherwise.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module zigzag_rle #(
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic [3:0]            out_run,
   output logic [DATA_WIDTH-1:0] out_value,
   output logic                  out_eob,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow
);
   import jpeg_pkg::*;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SCAN, S_EMIT
`ifdef ZIGZAG_RLE_ENCODE_EN
      , S_ZRL, S_EOB
`endif
   } state_t;

   state_t   r_state, w_state_nx;
   rle_sym_t r_sym, w_sym_nx;
   logic                  r_wr_bank, r_rd_bank, r_overflow, r_out_valid, w_valid_nx;
   logic [5:0]            r_wr_idx, r_k, w_k_nx, w_rd_k, w_rd_addr;
   logic [1:0]            r_full, w_set, w_clr;
   logic                  w_wbank, w_wr_en, w_wrap, w_drop;
   logic                  w_rd_en, w_done, w_xfer, w_last;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic signed [c_sym_value_w-1:0] w_coef;
   logic [3:0]            w_run;
   logic                  w_unused_value;
`ifdef ZIGZAG_RLE_ENCODE_EN
   logic [5:0]            r_zc, w_zc_nx;
   assign w_run = r_zc[3:0];
`else
   assign w_run = 4'd0;
`endif

   // Write side: a full write bank hands over to the other one as soon as it is empty.
   assign w_wbank = (r_full[r_wr_bank] && !r_full[~r_wr_bank]) ? ~r_wr_bank : r_wr_bank;
   assign w_wr_en = in_valid && !r_full[w_wbank];
   assign w_drop  = in_valid && !w_wr_en;
   assign w_wrap  = w_wr_en && (r_wr_idx == 6'd63);
   assign w_set   = w_wrap ? (w_wbank ? 2'b10 : 2'b01) : 2'b00;
   assign w_clr   = w_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_bank  <= 1'b0;
         r_wr_idx   <= '0;
         r_full     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_full     <= (r_full | w_set) & ~w_clr;
         r_overflow <= r_overflow | w_drop;
         r_wr_bank  <= (w_wrap && !r_full[~w_wbank]) ? ~w_wbank : w_wbank;
         if (w_wr_en) r_wr_idx <= r_wr_idx + 6'd1;
      end
   end

   assign w_rd_addr = c_zigzag_lut[w_rd_k];

   zigzag_pingpong_ram #(.DATA_WIDTH(DATA_WIDTH)) u_ram (
      .clk     (clk),
      .wr_en   (w_wr_en),
      .wr_bank (w_wbank),
      .wr_addr (r_wr_idx),
      .wr_data (in_data),
      .rd_en   (w_rd_en),
      .rd_bank (r_rd_bank),
      .rd_addr (w_rd_addr),
      .rd_data (w_rd_data)
   );

   assign w_coef = c_sym_value_w'($signed(w_rd_data));
   assign w_xfer = r_out_valid && out_ready;
   assign w_last = (r_k == 6'd63);

   // Leaving SCAN with a consumed coefficient prefetches k+1, so zero runs cost one cycle each.
   always_comb begin
      w_state_nx = r_state;
      w_k_nx     = r_k;
      w_sym_nx   = r_sym;
      w_valid_nx = r_out_valid;
      w_rd_en    = 1'b0;
      w_rd_k     = r_k + 6'd1;
      w_done     = 1'b0;
`ifdef ZIGZAG_RLE_ENCODE_EN
      w_zc_nx    = r_zc;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_full[r_rd_bank]) w_state_nx = S_FETCH;
         end
         S_FETCH: begin
            w_rd_en    = 1'b1;
            w_rd_k     = r_k;
            w_state_nx = S_SCAN;
         end
         S_SCAN: begin
`ifdef ZIGZAG_RLE_ENCODE_EN
            if ((r_k != 6'd0) && (w_coef == '0)) begin
               if (w_last) begin
                  w_sym_nx.run   = 4'd0;
                  w_sym_nx.value = '0;
                  w_sym_nx.eob   = 1'b1;
                  w_valid_nx     = 1'b1;
                  w_state_nx     = S_EOB;
               end else begin
                  w_zc_nx = r_zc + 6'd1;
                  w_k_nx  = r_k + 6'd1;
                  w_rd_en = 1'b1;
               end
            end else if (r_zc >= 6'd16) begin
               w_sym_nx.run   = c_zrl_run;
               w_sym_nx.value = '0;
               w_sym_nx.eob   = 1'b0;
               w_zc_nx        = r_zc - 6'd16;
               w_valid_nx     = 1'b1;
               w_state_nx     = S_ZRL;
            end else begin
               w_zc_nx = '0;
`endif
               w_sym_nx.run   = w_run;
               w_sym_nx.value = w_coef;
               w_sym_nx.eob   = w_last;
               w_valid_nx     = 1'b1;
               w_state_nx     = S_EMIT;
               if (!w_last) begin
                  w_k_nx  = r_k + 6'd1;
                  w_rd_en = 1'b1;
               end
`ifdef ZIGZAG_RLE_ENCODE_EN
            end
`endif
         end
         S_EMIT: begin
            if (w_xfer) begin
               w_valid_nx = 1'b0;
               if (r_sym.eob) w_done = 1'b1;
               else           w_state_nx = S_SCAN;
            end
         end
`ifdef ZIGZAG_RLE_ENCODE_EN
         S_ZRL: begin
            // The nonzero coefficient is still held in the RAM output register.
            if (w_xfer) begin
               w_valid_nx = 1'b0;
               w_state_nx = S_SCAN;
            end
         end
         S_EOB: begin
            if (w_xfer) begin
               w_valid_nx = 1'b0;
               w_done     = 1'b1;
            end
         end
`endif
         default: w_state_nx = S_IDLE;
      endcase
      if (w_done) begin
         w_state_nx = r_full[~r_rd_bank] ? S_FETCH : S_IDLE;
         w_k_nx     = '0;
`ifdef ZIGZAG_RLE_ENCODE_EN
         w_zc_nx    = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_sym       <= '0;
         r_out_valid <= 1'b0;
         r_rd_bank   <= 1'b0;
`ifdef ZIGZAG_RLE_ENCODE_EN
         r_zc        <= '0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_k         <= w_k_nx;
         r_sym       <= w_sym_nx;
         r_out_valid <= w_valid_nx;
         r_rd_bank   <= r_rd_bank ^ w_done;
`ifdef ZIGZAG_RLE_ENCODE_EN
         r_zc        <= w_zc_nx;
`endif
      end
   end

   assign w_unused_value = ^r_sym.value;

   assign out_run   = r_sym.run;
   assign out_value = r_sym.value[DATA_WIDTH-1:0];
   assign out_eob   = r_sym.eob;
   assign out_valid = r_out_valid;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_zigzag_rle.sv
// ============================================================================
// Module : tb_zigzag_rle
// Brief  : Directed blocks against a zigzag/run-length reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_zigzag_rle;

   localparam int DW = 10;

   typedef struct {
      int run;
      int value;
      bit eob;
   } sym_t;

   logic          clk, rst_n, in_valid, out_eob, out_valid, out_ready, overflow;
   logic [DW-1:0] in_data, out_value;
   logic [3:0]    out_run;

   sym_t exp_q[$];
   sym_t mdl_q[$];
   int   zz[64];
   int   blk[64];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 1;
   bit   stall = 0;
   logic [3:0]    st_run;
   logic [DW-1:0] st_value;
   logic          st_eob;

   zigzag_rle #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_run   (out_run),
      .out_value (out_value),
      .out_eob   (out_eob),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input bit ok, input string name, input string act, input string req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %s, required %s", name, act, req);
      end
   endtask

   function automatic sym_t mk(input int r, input int v, input bit e);
      sym_t s;
      s.run = r; s.value = v; s.eob = e;
      return s;
   endfunction

   // Zigzag order derived from anti-diagonal traversal of the 8x8 block.
   function automatic void build_zz();
      int n = 0;
      for (int s = 0; s < 15; s++)
         for (int i = 0; i < 8; i++) begin
            int r = (s % 2 == 1) ? i : 7 - i;
            int c = s - r;
            if (c >= 0 && c <= 7) begin
               zz[n] = r * 8 + c;
               n++;
            end
         end
   endfunction

   function automatic void model_block();
      int zc = 0;
      int v;
      mdl_q.delete();
      for (int k = 0; k < 64; k++) begin
         v = blk[zz[k]];
`ifdef ZIGZAG_RLE_ENCODE_EN
         if (k > 0 && v == 0) begin
            zc++;
            if (k == 63) mdl_q.push_back(mk(0, 0, 1'b1));
         end else begin
            while (zc >= 16) begin
               mdl_q.push_back(mk(15, 0, 1'b0));
               zc -= 16;
            end
            mdl_q.push_back(mk(zc, v, k == 63));
            zc = 0;
         end
`else
         mdl_q.push_back(mk(0, v, k == 63));
`endif
      end
   endfunction

   function automatic void expect_block();
      model_block();
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
   endfunction

   function automatic void set_dc50();
      foreach (blk[i]) blk[i] = 0;
      blk[0] = 50;
   endfunction

   function automatic void set_req036();
      foreach (blk[i]) blk[i] = 0;
      blk[0] = -3;
      blk[zz[1]] = 7;
      blk[zz[20]] = -1;
      blk[zz[63]] = 2;
   endfunction

   function automatic void set_ramp();
      foreach (blk[i]) blk[i] = i;
   endfunction

   function automatic void set_mix();
      foreach (blk[i]) blk[i] = (i % 11 == 0) ? ((i % 2 == 1) ? -(i * 5) : i * 7) : 0;
      blk[zz[5]] = -512;
      blk[zz[6]] = 511;
   endfunction

   task automatic monitor();
      sym_t e;
      if (stall)
         chk(out_valid && out_run == st_run && out_value == st_value && out_eob == st_eob,
             "stall_stable",
             $sformatf("v=%0b (%0d,%0d,%0b)", out_valid, out_run, $signed(out_value), out_eob),
             $sformatf("v=1 (%0d,%0d,%0b)", st_run, $signed(st_value), st_eob));
      if (out_valid && out_ready) begin
         chk(exp_q.size() > 0, "symbol_expected",
             $sformatf("extra (%0d,%0d,%0b)", out_run, $signed(out_value), out_eob), "none");
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(int'(out_run) == e.run && int'($signed(out_value)) == e.value && out_eob == e.eob,
                "symbol",
                $sformatf("(%0d,%0d,%0b)", out_run, $signed(out_value), out_eob),
                $sformatf("(%0d,%0d,%0b)", e.run, e.value, e.eob));
         end
      end
      stall    = out_valid && !out_ready;
      st_run   = out_run;
      st_value = out_value;
      st_eob   = out_eob;
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst_n) monitor();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic send_block(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(blk[i]);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic check_latency();
      int n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk(n == 3, "first_valid_latency", $sformatf("%0d", n), "3");
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      chk(n < budget, "drain", $sformatf("%0d left after %0d cycles", exp_q.size(), n), "all drained");
   endtask

   task automatic check_idle_outputs(input string tag);
      chk(out_valid == 1'b0, {tag, "_out_valid"}, $sformatf("%0b", out_valid), "0");
      chk(out_run == 4'd0, {tag, "_out_run"}, $sformatf("%0d", out_run), "0");
      chk(out_value == '0, {tag, "_out_value"}, $sformatf("%0d", out_value), "0");
      chk(out_eob == 1'b0, {tag, "_out_eob"}, $sformatf("%0b", out_eob), "0");
      chk(overflow == 1'b0, {tag, "_overflow"}, $sformatf("%0b", overflow), "0");
   endtask

   task automatic pin_model();
      int zl[6] = '{0, 1, 8, 16, 9, 2};
      for (int i = 0; i < 6; i++)
         chk(zz[i] == zl[i], "zigzag_table", $sformatf("%0d", zz[i]), $sformatf("%0d", zl[i]));
`ifdef ZIGZAG_RLE_ENCODE_EN
      begin
         int lr[7] = '{0, 0, 15, 2, 15, 15, 10};
         int lv[7] = '{-3, 7, 0, -1, 0, 0, 2};
         set_req036();
         model_block();
         chk(mdl_q.size() == 7, "model_req036_len", $sformatf("%0d", mdl_q.size()), "7");
         for (int i = 0; i < 7 && i < mdl_q.size(); i++)
            chk(mdl_q[i].run == lr[i] && mdl_q[i].value == lv[i] && mdl_q[i].eob == (i == 6),
                "model_req036",
                $sformatf("(%0d,%0d,%0b)", mdl_q[i].run, mdl_q[i].value, mdl_q[i].eob),
                $sformatf("(%0d,%0d,%0b)", lr[i], lv[i], i == 6));
         set_dc50();
         model_block();
         chk(mdl_q.size() == 2 && mdl_q[0].value == 50 && !mdl_q[0].eob &&
             mdl_q[1].run == 0 && mdl_q[1].value == 0 && mdl_q[1].eob,
             "model_dc50", $sformatf("%0d symbols", mdl_q.size()), "(0,50,0),(0,0,1)");
      end
`else
      begin
         int eobs = 0;
         set_ramp();
         model_block();
         chk(mdl_q.size() == 64, "model_ramp_len", $sformatf("%0d", mdl_q.size()), "64");
         for (int i = 0; i < 6 && i < mdl_q.size(); i++)
            chk(mdl_q[i].value == zl[i] && mdl_q[i].run == 0, "model_ramp",
                $sformatf("%0d", mdl_q[i].value), $sformatf("%0d", zl[i]));
         foreach (mdl_q[i]) if (mdl_q[i].eob) eobs++;
         chk(eobs == 1 && mdl_q[mdl_q.size()-1].eob, "model_ramp_eob", $sformatf("%0d", eobs), "1 on last");
      end
`endif
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      build_zz();
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("reset");
      pin_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single block, idle read side: first-symbol latency and DC-only block.
      ready_mode = 1;
      set_dc50();
      expect_block();
      send_block(64);
      check_latency();
      wait_drain(2000);

      ready_mode = 2;
      set_req036();
      expect_block();
      send_block(64);
      wait_drain(2000);

      ready_mode = 1;
      set_ramp();
      expect_block();
      send_block(64);
      wait_drain(2000);

      ready_mode = 2;
      set_mix();
      expect_block();
      send_block(64);
      wait_drain(2000);

      // Both banks fill under a stalled sink; the third block must be dropped.
      ready_mode = 0;
      set_req036();
      expect_block();
      send_block(64);
      set_ramp();
      expect_block();
      send_block(64);
      chk(overflow == 1'b0, "overflow_before_drop", $sformatf("%0b", overflow), "0");
      set_mix();
      send_block(64);
      chk(overflow == 1'b1, "overflow_on_drop", $sformatf("%0b", overflow), "1");
      repeat (10) tick();
      ready_mode = 2;
      wait_drain(3000);
      chk(overflow == 1'b1, "overflow_sticky", $sformatf("%0b", overflow), "1");
      set_dc50();
      expect_block();
      send_block(64);
      wait_drain(2000);

      // Reset in the middle of a partial block.
      ready_mode = 1;
      set_ramp();
      send_block(30);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("midblock_reset");
      stall = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_req036();
      expect_block();
      send_block(64);
      check_latency();
      wait_drain(2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/zigzag_rle.md
ZIGZAG_RLE -- requirements
Module: zigzag_rle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, the signed quantized-coefficient width.
REQ-002 SHALL have a single clock and an asynchronous active-low reset.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_data, input, DATA_WIDTH, signed quantized coefficient in raster order.
REQ-006 Port in_valid, input, 1, in_data valid; no backpressure toward the quantizer.
REQ-007 Port out_run, output, 4, count of zero coefficients preceding out_value.
REQ-008 Port out_value, output, DATA_WIDTH, signed coefficient value.
REQ-009 Port out_eob, output, 1, end-of-block marker.
REQ-010 Port out_valid, output, 1, symbol valid.
REQ-011 Port out_ready, input, 1, downstream accepts the symbol.
REQ-012 Port overflow, output, 1, sticky flag set when an input is dropped.

Function
REQ-013 SHALL hold two 64-entry banks: the write bank fills while the read bank drains.
REQ-014 Each in_valid cycle SHALL write to raster index wr_idx (0..63); wr_idx SHALL wrap 63->0 and mark the bank full.
REQ-015 On a bank going full with the other bank empty, the roles SHALL swap in the same cycle; otherwise writes SHALL continue only into a non-full bank.
REQ-016 An in_valid arriving while both banks are full SHALL be dropped, leave wr_idx unchanged and set overflow.
REQ-017 The read side SHALL visit indices in JPEG zigzag order (LUT entry k = raster index of k-th zigzag element).
REQ-018 A symbol SHALL transfer when out_valid and out_ready are both high; out_valid and all out_* SHALL stay stable while out_ready is low.
REQ-019 Read FSM states SHALL be IDLE, FETCH, SCAN, ZRL, EMIT and EOB.
REQ-020 IDLE->FETCH on read bank full; FETCH performs the 1-cycle synchronous RAM read; SCAN evaluates the coefficient.
REQ-021 k=0 (DC) SHALL always emit run=0, value=coefficient.
REQ-022 An AC zero SHALL increment zero_cnt (6 bits) and emit nothing.
REQ-023 An AC nonzero SHALL emit one ZRL symbol (run=15, value=0) per 16 zeros in zero_cnt, then (run=zero_cnt mod 16, value), then clear zero_cnt.
REQ-024 After k=63: if zero_cnt>0, SHALL emit EOB (run=0, value=0, out_eob=1); ZRLs for trailing zeros SHALL never be emitted.
REQ-025 If k=63 is nonzero, its symbol SHALL carry out_eob=1 and no separate EOB is emitted.
REQ-026 After the final symbol transfers, the bank SHALL be marked empty and the FSM SHALL go to IDLE, or to FETCH if the other bank is full.
REQ-027 First out_valid SHALL be asserted 3 cycles after the clock edge sampling the 64th in_valid, when the read side is idle.
REQ-028 Sustained throughput with out_ready=1 SHALL be at least one coefficient per cycle while scanning zeros.

Reset
REQ-029 While rst_n is low: out_valid=0, out_run=0, out_value=0, out_eob=0, overflow=0, both banks empty, wr_idx=0, zero_cnt=0, FSM=IDLE.
REQ-030 Reset mid-block SHALL discard partial blocks; bank RAM contents need not be cleared.

Configuration
REQ-031 With macro ZIGZAG_RLE_ENCODE_EN defined, the module SHALL perform run-length coding per REQ-021..REQ-025.
REQ-032 Without the macro, it SHALL emit 64 symbols per block in zigzag order, run=0, value=coefficient, out_eob=1 on k=63, and no ZRL or EOB states.

Structure
REQ-033 Package jpeg_pkg SHALL hold the 64-entry zigzag LUT, the ZRL run constant 15, and typedef rle_sym_t {run, value, eob}.
REQ-034 The dual-bank RAM SHALL be sub-module zigzag_pingpong_ram, with one write port and one synchronous read port.

Verification
REQ-035 Block with DC=50 and all AC=0 -> symbols (0,50), EOB; out_eob=1 on the EOB only.
REQ-036 DC=-3, zigzag k=1 = 7, k=20 = -1, k=63 = 2 -> (0,-3), (0,7), (15,0), (2,-1), (15,0), (15,0), (10,2) with out_eob=1; no separate EOB.
REQ-037 Two back-to-back blocks with out_ready held low for 200 cycles -> both blocks output intact in order; a third block's inputs are dropped and overflow=1.
REQ-038 Random out_ready toggling -> symbol stream identical to the out_ready=1 run; outputs stable during stalls.
REQ-039 rst_n pulsed low at input index 30 -> all outputs 0; the next full block encodes correctly from wr_idx=0.
REQ-040 Without ZIGZAG_RLE_ENCODE_EN, raster input value = index -> 64 outputs 0,1,8,16,9,2,... with out_eob=1 only on the 64th.
